sreg_word_capture: RTL and testbench

//  Downstream framing stage for the sreg_p serial-in shift register. It watches the same
//  S0 shift strobe, counts N shifts and captures the completed parallel word from the

---
 rtl/sreg_word_capture_pkg.sv | 18 +
 rtl/sreg_fifo2.sv | 81 ++++++++
 rtl/sreg_word_capture.sv | 93 +++++++++
 tb/tb_sreg_word_capture.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sreg_word_capture_pkg.sv
// rtl/sreg_word_capture_pkg.sv - shared constants and helpers for the word capture stage
// Counter width rule, buffer depth and reset values used by the top and the FIFO.
package sreg_word_capture_pkg;

   localparam int FIFO_DEPTH = 2;

   localparam logic RST_VALID = 1'b0;
   localparam logic RST_OVR   = 1'b0;
   localparam logic RST_PEND  = 1'b0;

   typedef logic [1:0] occ_t;

   // Shift counter must hold 0..N-1 and is never narrower than one bit.
   function automatic int cw_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sreg_fifo2.sv
// rtl/sreg_fifo2.sv - two-entry word buffer with head register driving DO
// Push and pop may coincide at any occupancy; a push into a full buffer with no pop is ignored.
module sreg_fifo2
   import sreg_word_capture_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         CLK,
   input  logic         CLR,
   input  logic         PUSH,
   input  logic [N-1:0] DI,
   input  logic         POP,
   output logic [N-1:0] DO,
   output logic         NE,
   output logic         FULL
);

   localparam occ_t OCC_EMPTY = occ_t'(0);
   localparam occ_t OCC_ONE   = occ_t'(1);
   localparam occ_t OCC_FULL  = occ_t'(FIFO_DEPTH);

   logic [N-1:0] head_q, head_d;
   logic [N-1:0] tail_q, tail_d;
   occ_t         occ_q, occ_d;
   logic         pop_ok;
   logic         push_ok;

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= OCC_EMPTY;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      occ_d   = occ_q;
      pop_ok  = POP && (occ_q != OCC_EMPTY);
      push_ok = PUSH && ((occ_q != OCC_FULL) || pop_ok);
      case ({push_ok, pop_ok})
         2'b10: begin
            if (occ_q == OCC_EMPTY) begin
               head_d = DI;
               occ_d  = OCC_ONE;
            end else begin
               tail_d = DI;
               occ_d  = OCC_FULL;
            end
         end
         2'b01: begin
            if (occ_q == OCC_FULL) begin
               head_d = tail_q;
            end
            occ_d = occ_q - OCC_ONE;
         end
         2'b11: begin
            // Occupancy is unchanged; the new word lands behind whatever remains.
            if (occ_q == OCC_ONE) begin
               head_d = DI;
            end else begin
               head_d = tail_q;
               tail_d = DI;
            end
         end
         default: begin
            head_d = head_q;
         end
      endcase
   end

   assign DO   = head_q;
   assign NE   = (occ_q != OCC_EMPTY);
   assign FULL = (occ_q == OCC_FULL);

endmodule

// File: rtl/sreg_word_capture.sv
// rtl/sreg_word_capture.sv - frames shift-register output into words behind a VALID/READY buffer
// Counts S0 strobes, captures Q one cycle after the Nth shift, flags dropped words on OVR.
module sreg_word_capture
   import sreg_word_capture_pkg::*;
#(
   parameter int N      = 8,
   parameter int DPFLAG = 1,
   parameter     GROUP  = "dpath1",
   localparam int CW    = cw_of(N)
) (
   input  logic          CLK,
   input  logic          CLR,
   input  logic          S0,
   input  logic          SYNC,
   input  logic [N-1:0]  DIN,
   output logic [N-1:0]  DOUT,
   output logic          VALID,
   input  logic          READY,
   output logic          OVR,
   input  logic          OVR_CLR,
   output logic [CW-1:0] CNT
);

   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic          ovr_q, ovr_d;
   logic          fifo_ne;
   logic          fifo_full;
   logic          pop;
   logic          unused_attrs;

   assign unused_attrs = (DPFLAG != 0) ^ (GROUP == "");

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         cnt_q  <= '0;
         pend_q <= RST_PEND;
         ovr_q  <= RST_OVR;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      pend_d = 1'b0;
      // SYNC only stops a new capture being scheduled; a word already pending still lands.
      if (SYNC) begin
         cnt_d = '0;
      end else if (S0) begin
         if (cnt_q == LAST) begin
            cnt_d  = '0;
            pend_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign pop = fifo_ne && READY;

   always_comb begin
      ovr_d = ovr_q;
      if (OVR_CLR) begin
         ovr_d = 1'b0;
      end
      if (pend_q && fifo_full && !pop) begin
         ovr_d = 1'b1;
      end
   end

   sreg_fifo2 #(
      .N(N)
   ) u_fifo (
      .CLK  (CLK),
      .CLR  (CLR),
      .PUSH (pend_q),
      .DI   (DIN),
      .POP  (pop),
      .DO   (DOUT),
      .NE   (fifo_ne),
      .FULL (fifo_full)
   );

   assign VALID = fifo_ne | RST_VALID;
   assign OVR   = ovr_q;
   assign CNT   = cnt_q;

endmodule

// File: tb/tb_sreg_word_capture.sv
// tb/tb_sreg_word_capture.sv - scoreboard bench for sreg_word_capture with N=8
// Stimulus queues expected words; a negedge monitor checks every accepted DOUT in order.
module tb_sreg_word_capture;

   localparam int N = 8;

   logic       CLK = 1'b0;
   logic       CLR;
   logic       S0;
   logic       SYNC;
   logic [7:0] DIN;
   logic [7:0] DOUT;
   logic       VALID;
   logic       READY;
   logic       OVR;
   logic       OVR_CLR;
   logic [2:0] CNT;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];

   always #5 CLK = ~CLK;

   sreg_word_capture #(
      .N(N)
   ) dut (
      .CLK     (CLK),
      .CLR     (CLR),
      .S0      (S0),
      .SYNC    (SYNC),
      .DIN     (DIN),
      .DOUT    (DOUT),
      .VALID   (VALID),
      .READY   (READY),
      .OVR     (OVR),
      .OVR_CLR (OVR_CLR),
      .CNT     (CNT)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (!CLR && VALID && READY) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got word %0h expected none at %0t", DOUT, $time);
         end else begin
            chk("sb_word", int'(DOUT), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         S0 = 1'b1;
         tick();
      end
      S0 = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input bit expect_it);
      pulses(N - 1);
      S0  = 1'b1;
      DIN = w;
      tick();
      S0  = 1'b0;
      if (expect_it) exp_q.push_back(w);
   endtask

   task automatic drain();
      READY = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (exp_q.size() == 0 && !VALID) break;
      end
      chk("drain_valid", int'(VALID), 0);
      chk("drain_queue", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      CLR = 1'b1; S0 = 1'b0; SYNC = 1'b0; DIN = 8'h00; READY = 1'b0; OVR_CLR = 1'b0;
      tick();
      tick();
      CLR = 1'b0;
      tick();
      chk("rst_valid", int'(VALID), 0);
      chk("rst_ovr", int'(OVR), 0);
      chk("rst_cnt", int'(CNT), 0);
      chk("rst_dout", int'(DOUT), 0);

      // single word, consumer always ready
      READY = 1'b1;
      send_word(8'hA5, 1'b1);
      chk("w1_cnt", int'(CNT), 0);
      chk("w1_pend_valid", int'(VALID), 0);
      tick();
      chk("w1_valid", int'(VALID), 1);
      chk("w1_dout", int'(DOUT), 8'hA5);
      tick();
      chk("w1_valid_drop", int'(VALID), 0);

      // overrun with a stalled consumer
      READY = 1'b0;
      send_word(8'h11, 1'b1);
      send_word(8'h22, 1'b1);
      send_word(8'h33, 1'b0);
      tick();
      chk("ovr_set", int'(OVR), 1);
      chk("ovr_head", int'(DOUT), 8'h11);
      drain();
      chk("ovr_sticky", int'(OVR), 1);
      OVR_CLR = 1'b1;
      tick();
      OVR_CLR = 1'b0;
      chk("ovr_cleared", int'(OVR), 0);

      // SYNC discards a partial word
      READY = 1'b1;
      pulses(5);
      chk("sync_pre_cnt", int'(CNT), 5);
      SYNC = 1'b1;
      tick();
      SYNC = 1'b0;
      chk("sync_cnt", int'(CNT), 0);
      pulses(7);
      chk("sync_cnt7", int'(CNT), 7);
      chk("sync_no_capture", int'(VALID), 0);
      S0  = 1'b1;
      DIN = 8'h5C;
      tick();
      S0  = 1'b0;
      exp_q.push_back(8'h5C);
      drain();

      // full buffer: final shift of word 3 coincides with a pop
      READY = 1'b0;
      send_word(8'h11, 1'b1);
      send_word(8'h22, 1'b1);
      pulses(N - 1);
      S0    = 1'b1;
      DIN   = 8'h33;
      READY = 1'b1;
      tick();
      S0    = 1'b0;
      READY = 1'b0;
      exp_q.push_back(8'h33);
      tick();
      chk("pop_ovr", int'(OVR), 0);
      chk("pop_head", int'(DOUT), 8'h22);

      // push and pop together while full
      pulses(N - 1);
      S0  = 1'b1;
      DIN = 8'h44;
      tick();
      S0  = 1'b0;
      exp_q.push_back(8'h44);
      READY = 1'b1;
      tick();
      READY = 1'b0;
      chk("pp_full_ovr", int'(OVR), 0);
      chk("pp_full_head", int'(DOUT), 8'h33);
      tick();
      chk("hold_head", int'(DOUT), 8'h33);
      chk("hold_valid", int'(VALID), 1);
      drain();

      // OVR_CLR in the same cycle as an overrun push: set wins
      READY = 1'b0;
      send_word(8'h66, 1'b1);
      send_word(8'h77, 1'b1);
      send_word(8'h88, 1'b0);
      chk("setwin_pre", int'(OVR), 0);
      OVR_CLR = 1'b1;
      tick();
      OVR_CLR = 1'b0;
      chk("setwin_ovr", int'(OVR), 1);
      OVR_CLR = 1'b1;
      tick();
      OVR_CLR = 1'b0;
      chk("setwin_clr", int'(OVR), 0);

      // asynchronous CLR mid-word with a full buffer and OVR set
      send_word(8'h99, 1'b0);
      tick();
      chk("clr_pre_ovr", int'(OVR), 1);
      pulses(3);
      chk("clr_pre_cnt", int'(CNT), 3);
      @(posedge CLK);
      #2;
      CLR = 1'b1;
      #1;
      chk("clr_valid", int'(VALID), 0);
      chk("clr_ovr", int'(OVR), 0);
      chk("clr_cnt", int'(CNT), 0);
      chk("clr_dout", int'(DOUT), 0);
      exp_q.delete();
      tick();
      CLR = 1'b0;
      tick();
      chk("clr_post_valid", int'(VALID), 0);
      READY = 1'b1;
      send_word(8'hAB, 1'b1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
